// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared timing constants and types for the VGA raster generator.
//   - DEF_* : 640x480@60 default timing (pixels / lines).
//   - DEF_H_TOTAL / DEF_V_TOTAL : derived totals (800 / 525).
//   - CNT_W / CNT_MAX_TOTAL : counter width and the largest total it can hold.
//   - cnt_t   : raster counter type.
//   - phase_e : per-axis phase, walked ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
//   - next_phase() : successor of a phase in that cycle.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned CNT_W         = 10;
  localparam int unsigned CNT_MAX_TOTAL = 1 << CNT_W;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_e;

  function automatic phase_e next_phase(input phase_e ph);
    phase_e nxt;
    case (ph)
      PH_ACTIVE: nxt = PH_FP;
      PH_FP:     nxt = PH_SYNC;
      PH_SYNC:   nxt = PH_BP;
      PH_BP:     nxt = PH_ACTIVE;
      default:   nxt = PH_ACTIVE;
    endcase
    return nxt;
  endfunction

endpackage : vga_timing_pkg

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   One raster axis (horizontal or vertical): a wrapping position counter, a
//   phase FSM tracking ACTIVE/FP/SYNC/BP, a registered sync output and a
//   combinational "next position is visible" flag. All outputs that depend on
//   position are computed from the NEXT count so they change on the same edge
//   as the count itself.
//
// Parameters: ACTIVE, FP, SYNC, BP (lengths, each >= 1), POL (asserted sync level)
// Ports:
//   clk_i        in   clock
//   rst_i        in   asynchronous reset, active-high
//   adv_i        in   advance the axis by one on this edge
//   count_o      out  current position 0..TOTAL-1 (resets to TOTAL-1)
//   wrap_o       out  comb: adv_i while at TOTAL-1 (count returns to 0 this edge)
//   sync_o       out  registered sync at POL polarity
//   active_nx_o  out  comb: position after this edge lies in the active region
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter bit          POL    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic adv_i,
  output cnt_t count_o,
  output logic wrap_o,
  output logic sync_o,
  output logic active_nx_o
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  // Last position of each phase; the FSM leaves a phase when advancing from it.
  localparam cnt_t LAST_ACTIVE = cnt_t'(ACTIVE - 1);
  localparam cnt_t LAST_FP     = cnt_t'(ACTIVE + FP - 1);
  localparam cnt_t LAST_SYNC   = cnt_t'(ACTIVE + FP + SYNC - 1);
  localparam cnt_t LAST        = cnt_t'(TOTAL - 1);

  if (TOTAL > CNT_MAX_TOTAL) begin : g_bad_total
    $error("vga_axis_counter: total %0d does not fit the %0d-bit counter", TOTAL, CNT_W);
  end
  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_phase
    $error("vga_axis_counter: every phase length must be at least 1");
  end

  cnt_t   count_q, count_d;
  phase_e phase_q, phase_d;
  logic   sync_q,  sync_d;
  logic   at_last;

  // Position counter next state.
  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    at_last = (count_q == LAST);
    wrap_o  = adv_i & at_last;
    count_d = count_q;
    if (adv_i) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  // Phase FSM next state: a transition fires only on an advance out of the
  // last position of the current phase.
  always_comb begin
    phase_d = phase_q;
    if (adv_i) begin
      case (phase_q)
        PH_ACTIVE: if (count_q == LAST_ACTIVE) phase_d = next_phase(phase_q);
        PH_FP:     if (count_q == LAST_FP)     phase_d = next_phase(phase_q);
        PH_SYNC:   if (count_q == LAST_SYNC)   phase_d = next_phase(phase_q);
        PH_BP:     if (at_last)                phase_d = next_phase(phase_q);
        default:   phase_d = PH_BP;
      endcase
    end
  end

  // Phase FSM outputs, decoded from the next phase (zero skew against count).
  always_comb begin
    sync_d      = (phase_d == PH_SYNC) ? POL : ~POL;
    active_nx_o = (phase_d == PH_ACTIVE);
  end

  // State register. Reset parks the axis at its last position (inside BP) so
  // the first advance lands on position 0 at the start of ACTIVE.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= LAST;
      phase_q <= PH_BP;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o = count_q;
  assign sync_o  = sync_q;

endmodule : vga_axis_counter

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   Free-running VGA raster timing generator on wb_clk_i. A prescaler produces
//   a pixel tick every CLK_DIV cycles; a horizontal axis counter advances on
//   each tick and a vertical one on each horizontal wrap. hsync/vsync/active
//   are registered and change on the same edge as x/y.
//
// Optional feature (macro VGA_FRAME_COUNT_EN): adds an 8-bit frame_cnt output
// counting frame starts (wraps 255 -> 0). Without the macro the port and the
// register do not exist.
//
// Ports:
//   wb_clk_i     in   system clock
//   wb_rst_i     in   asynchronous reset, active-high
//   en           in   run enable; 0 freezes prescaler and raster
//   pix_tick     out  1-cycle strobe; x/y/sync advance on this cycle's edge
//   x            out  [9:0] horizontal position 0..H_TOTAL-1
//   y            out  [9:0] vertical position 0..V_TOTAL-1
//   active       out  x < H_ACTIVE and y < V_ACTIVE
//   hsync        out  horizontal sync, asserted level HSYNC_POL
//   vsync        out  vertical sync, asserted level VSYNC_POL
//   line_start   out  one cycle high when x first reads 0
//   frame_start  out  one cycle high when (x,y) first reads (0,0)
//   frame_cnt    out  [7:0] frames started (VGA_FRAME_COUNT_EN only)
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  // Prescaler width; CLK_DIV == 1 still gets a (constant-zero) 1-bit register.
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be at least 1");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          active_q, active_d;

  logic h_wrap, v_wrap;
  logic h_sync, v_sync;
  logic h_active_nx, v_active_nx;
  cnt_t h_count, v_count;

  // Pixel tick is a decode of the registered prescaler, gated by en so a
  // frozen generator never strobes.
  always_comb begin
    pix_tick = en & (presc_q == PRESC_LAST);
    presc_d  = presc_q;
    if (en) begin
      presc_d = pix_tick ? '0 : presc_q + 1'b1;
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL)
  ) u_h_axis (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .adv_i       (pix_tick),
    .count_o     (h_count),
    .wrap_o      (h_wrap),
    .sync_o      (h_sync),
    .active_nx_o (h_active_nx)
  );

  // The vertical axis steps once per line, on the horizontal wrap strobe.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL)
  ) u_v_axis (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .adv_i       (h_wrap),
    .count_o     (v_count),
    .wrap_o      (v_wrap),
    .sync_o      (v_sync),
    .active_nx_o (v_active_nx)
  );

  // Pulses are registered versions of the wrap strobes: high for exactly the
  // cycle in which the new position is first visible.
  always_comb begin
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    active_d      = h_active_nx & v_active_nx;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      presc_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      active_q      <= active_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Counts on the same edge that raises frame_start; wraps naturally at 8 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_wrap) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign x           = h_count;
  assign y           = v_count;
  assign active      = active_q;
  assign hsync       = h_sync;
  assign vsync       = v_sync;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule : vga_sync_gen

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Self-checking bench for vga_sync_gen using a shrunken raster (15 x 10) so
//   whole frames fit in a short run. Expected outputs come from closed-form
//   functions of the number of pixel ticks since reset; one record is pushed
//   per clock and popped/compared on the falling edge.
//   With VGA_FRAME_COUNT_EN defined the DUT runs at CLK_DIV=1 and the
//   frame_cnt wrap after 257 frame starts is checked.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VA = 5, VF = 1, VS = 2, VB = 2;
  localparam int unsigned HT = HA + HF + HS + HB;  // 15
  localparam int unsigned VT = VA + VF + VS + VB;  // 10
`ifdef VGA_FRAME_COUNT_EN
  localparam int unsigned CD = 1;
`else
  localparam int unsigned CD = 4;
`endif

  logic       clk, rst, en;
  logic       pix_tick, active, hsync, vsync, line_start, frame_start;
  logic [9:0] x, y;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt;
`endif

  vga_sync_gen #(
    .CLK_DIV   (CD),
    .H_ACTIVE  (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE  (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HSYNC_POL (1'b0),
    .VSYNC_POL (1'b0)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .en          (en),
    .pix_tick    (pix_tick),
    .x           (x),
    .y           (y),
    .active      (active),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int          checks   = 0;
  int          failures = 0;
  int unsigned ecount;   // enabled clock edges since reset
  int unsigned t_cnt;    // pixel ticks since reset
  int unsigned fs_seen;  // frame starts since reset

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Raster position after t ticks; t == 0 is the reset parking position.
  function automatic int unsigned mx(input int unsigned t);
    return (t == 0) ? HT - 1 : (t - 1) % HT;
  endfunction

  function automatic int unsigned my(input int unsigned t);
    return (t == 0) ? VT - 1 : ((t - 1) / HT) % VT;
  endfunction

  task automatic model_reset();
    ecount  = 0;
    t_cnt   = 0;
    fs_seen = 0;
  endtask

  // One clock edge with the current en; afterwards en takes en_v and the
  // expected post-edge outputs are queued.
  task automatic step(input logic en_v);
    logic tick_now;
    exp_t e;
    @(posedge clk);
    tick_now = en && ((ecount % CD) == CD - 1);
    if (en) ecount++;
    if (tick_now) t_cnt++;
    #1;
    en    = en_v;
    e.pt  = en_v && ((ecount % CD) == CD - 1);
    e.x   = 10'(mx(t_cnt));
    e.y   = 10'(my(t_cnt));
    e.act = (mx(t_cnt) < HA) && (my(t_cnt) < VA);
    e.hs  = !((mx(t_cnt) >= HA + HF) && (mx(t_cnt) <= HA + HF + HS - 1));
    e.vs  = !((my(t_cnt) >= VA + VF) && (my(t_cnt) <= VA + VF + VS - 1));
    e.ls  = tick_now && (mx(t_cnt) == 0);
    e.fs  = tick_now && (mx(t_cnt) == 0) && (my(t_cnt) == 0);
    if (e.fs) fs_seen++;
    e.fc  = 8'(fs_seen);
    sb.push_back(e);
  endtask

  task automatic run_ticks(input int unsigned n);
    int unsigned target;
    int          guard;
    target = t_cnt + n;
    guard  = 0;
    while (t_cnt < target && guard < 20000) begin
      step(1'b1);
      guard++;
    end
    chk("run_ticks_reached", t_cnt, target);
  endtask

  task automatic seek(input int unsigned xt, input int unsigned yt);
    int guard;
    guard = 0;
    while (!(t_cnt != 0 && mx(t_cnt) == xt && my(t_cnt) == yt) && guard < 20000) begin
      step(1'b1);
      guard++;
    end
    chk("seek_x", x, xt);
    chk("seek_y", y, yt);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pix_tick"}, pix_tick, 1'b0);
    chk({tag, "_x"}, x, HT - 1);
    chk({tag, "_y"}, y, VT - 1);
    chk({tag, "_active"}, active, 1'b0);
    chk({tag, "_hsync"}, hsync, 1'b1);
    chk({tag, "_vsync"}, vsync, 1'b1);
    chk({tag, "_line_start"}, line_start, 1'b0);
    chk({tag, "_frame_start"}, frame_start, 1'b0);
`ifdef VGA_FRAME_COUNT_EN
    chk({tag, "_frame_cnt"}, frame_cnt, 8'd0);
`endif
  endtask

  // Scoreboard consumer: compare one queued record per falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("pix_tick", pix_tick, mon_e.pt);
      chk("x", x, mon_e.x);
      chk("y", y, mon_e.y);
      chk("active", active, mon_e.act);
      chk("hsync", hsync, mon_e.hs);
      chk("vsync", vsync, mon_e.vs);
      chk("line_start", line_start, mon_e.ls);
      chk("frame_start", frame_start, mon_e.fs);
`ifdef VGA_FRAME_COUNT_EN
      chk("frame_cnt", frame_cnt, mon_e.fc);
`endif
    end
  end

  initial begin
    int unsigned x_frozen;
    rst = 1'b1;
    en  = 1'b0;
    model_reset();

    // Reset is asynchronous: outputs are in the reset state before any edge.
    #3;
    chk_reset_state("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First tick lands on (0,0) with frame_start; then two full frames cover
    // every hsync/vsync/active/line_start boundary.
    step(1'b1);
    run_ticks(2 * HT * VT + 5);

    // Freeze mid-line and mid-prescaler for 37 edges, then resume.
    seek(5, 2);
    step(1'b1);
    x_frozen = mx(t_cnt);
    step(1'b0);
    repeat (36) step(1'b0);
    chk("freeze_x_held", x, x_frozen);
    chk("freeze_y_held", y, 2);
    step(1'b1);
    run_ticks(HT + 2);

    // Asynchronous reset in the middle of a frame.
    seek(12, 3);
    @(negedge clk);
    #1;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1);
    run_ticks(HT * VT + 3);

`ifdef VGA_FRAME_COUNT_EN
    begin
      int guard;
      guard = 0;
      while (fs_seen < 257 && guard < 60000) begin
        step(1'b1);
        guard++;
      end
      chk("frames_run", fs_seen, 257);
      chk("frame_cnt_wrapped", frame_cnt, 8'd1);
    end
`endif

    repeat (2) @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vga_sync_gen
